// File: rtl/div_seq_unit.sv
// Multicycle restoring shift-subtract divider for DIV/DIVU, MIPS truncating semantics.
// Optional define DIV_SEQ_UNSIGNED_EN adds the is_unsigned input for DIVU.
module div_seq_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SEQ_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_ZERO
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remn_q, remn_d;
   logic             done_q, done_d;

   logic             uns;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH:0]   shift;
   logic [WIDTH:0]   trial;

`ifdef DIV_SEQ_UNSIGNED_EN
   assign uns = is_unsigned;
`else
   assign uns = 1'b0;
`endif

   assign a_neg = dividend[WIDTH-1] & ~uns;
   assign b_neg = divisor[WIDTH-1] & ~uns;

   // Partial remainder is WIDTH+1 bits: the shifted remainder plus the next dividend bit.
   assign shift = {rem_q, dvd_q[WIDTH-1]};
   assign trial = shift - {1'b0, dvs_q};

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      quot_d  = quot_q;
      remn_d  = remn_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  state_d = S_ZERO;
               end else begin
                  dvd_d   = a_neg ? -dividend : dividend;
                  dvs_d   = b_neg ? -divisor : divisor;
                  negq_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (trial[WIDTH]) begin
               rem_d = shift[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            end else begin
               rem_d = trial[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            quot_d  = negq_q ? -dvd_q : dvd_q;
            remn_d  = negr_q ? -rem_q : rem_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_ZERO: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         quot_q  <= '0;
         remn_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         quot_q  <= quot_d;
         remn_q  <= remn_d;
         done_q  <= done_d;
      end
   end

   assign quotient  = quot_q;
   assign remainder = remn_q;
   assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
   assign done      = done_q;
   assign div_zero  = (state_q == S_ZERO);

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed bench for div_seq_unit: latency, signs, divide-by-zero, overflow, abort.
// Define DIV_SEQ_UNSIGNED_EN to also exercise the unsigned path.
module tb_div_seq_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        is_unsigned;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_zero;

   int errors = 0;
   int checks = 0;

   div_seq_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
`ifdef DIV_SEQ_UNSIGNED_EN
      .is_unsigned(is_unsigned),
`endif
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_div(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er);
      int lat;
      lat = 0;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, "_busy_run"}, {31'b0, busy}, 32'd1);
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge clk);
         #1;
         if (done) lat = k;
      end
      chk({tag, "_latency"}, lat, 32'd33);
      chk({tag, "_quot"}, quotient, eq);
      chk({tag, "_rem"}, remainder, er);
      chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
      chk({tag, "_dz_done"}, {31'b0, div_zero}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      int seen;
      reset       = 1'b1;
      start       = 1'b0;
      dividend    = '0;
      divisor     = '0;
      is_unsigned = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_quot", quotient, 32'd0);
      chk("rst_rem", remainder, 32'd0);
      chk("rst_flags", {29'b0, busy, done, div_zero}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // T1
      run_div("t1", 32'd7, 32'd2, 32'd3, 32'd1);

      // T3: divide by zero keeps prior results
      @(negedge clk);
      dividend = 32'd5;
      divisor  = 32'd0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("t3_dz_pulse", {31'b0, div_zero}, 32'd1);
      chk("t3_done_low", {31'b0, done}, 32'd0);
      chk("t3_busy_low", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk("t3_dz_end", {31'b0, div_zero}, 32'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk("t3_no_done", seen, 32'd0);
      chk("t3_quot", quotient, 32'd3);
      chk("t3_rem", remainder, 32'd1);

      // T2
      run_div("t2a", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_div("t2b", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
      run_div("negneg", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
      run_div("zero_dvd", 32'd0, 32'd5, 32'd0, 32'd0);
      run_div("big", 32'd1000000, 32'd37, 32'd27027, 32'd1);

      // T4: overflow wraps
      run_div("t4", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

      // T5: ignored restart, then reset aborts
      @(negedge clk);
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("t5_busy_mid", {31'b0, busy}, 32'd1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("t5_quot", quotient, 32'd0);
      chk("t5_rem", remainder, 32'd0);
      chk("t5_flags", {29'b0, busy, done, div_zero}, 32'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk("t5_no_done", seen, 32'd0);
      run_div("t5_after", 32'd100, 32'd7, 32'd14, 32'd2);

`ifdef DIV_SEQ_UNSIGNED_EN
      // T6
      is_unsigned = 1'b1;
      run_div("t6_u", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
      is_unsigned = 1'b0;
      run_div("t6_s", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
